// File: rtl/mult_pkg.sv
// Shared types and widths for the sequential shift-add multiplier.
package mult_pkg;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;
endpackage

// File: rtl/shift_add_mult_rca.sv
// 8-bit ripple-carry adder shared by the multiplier datapath.
module RCA (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Ci,
    output logic [7:0] S,
    output logic       Co
);
    logic [8:0] w_carry;

    assign w_carry[0] = Ci;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_fa
            assign S[gi]         = A[gi] ^ B[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (A[gi] & B[gi]) | (w_carry[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign Co = w_carry[8];
endmodule

// File: rtl/shift_add_mult.sv
// Sequential 8x8 unsigned shift-add multiplier around one shared RCA.
// Optional macro MULT_EARLY_EXIT_EN finishes early once no multiplier bits remain.
module shift_add_mult
    import mult_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic                done_valid,
    input  logic                done_ready,
    output logic [PROD_W-1:0]   product,
    output logic                busy
);
    mult_state_t        r_state;
    mult_state_t        w_state_next;
    logic [OP_W-1:0]    r_mcand;
    logic [OP_W-1:0]    r_acc;
    logic [OP_W-1:0]    r_mplr;
    logic [CNT_W-1:0]   r_cnt;

    logic [OP_W-1:0]    w_sum;
    logic               w_co;
    logic               w_last_step;

    RCA u_rca (
        .A  (r_acc),
        .B  (r_mcand),
        .Ci (1'b0),
        .S  (w_sum),
        .Co (w_co)
    );

    assign w_last_step = (r_cnt == CNT_W'(OP_W - 1));

`ifdef MULT_EARLY_EXIT_EN
    // Low (8-cnt) bits of mplr are the multiplier bits not yet consumed.
    logic [OP_W-1:0]    w_rem_mask;
    logic [CNT_W-1:0]   w_shamt;
    logic [PROD_W-1:0]  w_shifted;
    logic               w_early;

    assign w_rem_mask = {OP_W{1'b1}} >> r_cnt;
    assign w_shamt    = CNT_W'(OP_W) - r_cnt;
    assign w_shifted  = {r_acc, r_mplr} >> w_shamt;
    assign w_early    = ((r_mplr & w_rem_mask) == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start_valid) w_state_next = RUN;
`ifdef MULT_EARLY_EXIT_EN
            RUN:  if (w_early || w_last_step) w_state_next = DONE;
`else
            RUN:  if (w_last_step) w_state_next = DONE;
`endif
            DONE: if (done_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_mcand <= a;
                        r_acc   <= '0;
                        r_mplr  <= b;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
`ifdef MULT_EARLY_EXIT_EN
                    if (w_early) {r_acc, r_mplr} <= w_shifted;
                    else
`endif
                    // Carry-out becomes the top bit of the shifted partial sum.
                    if (r_mplr[0]) {r_acc, r_mplr} <= {w_co, w_sum, r_mplr[OP_W-1:1]};
                    else           {r_acc, r_mplr} <= {1'b0, r_acc, r_mplr[OP_W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (r_state == IDLE);
    assign done_valid  = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign product     = {r_acc, r_mplr};
endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: transaction-level model plus directed vectors.
// Build with +define+MULT_EARLY_EXIT_EN to check the early-exit variant.
module tb_shift_add_mult;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        done_valid;
    logic        done_ready;
    logic [15:0] product;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    // Model: 0 = idle, 1 = computing, 2 = result waiting
    int          m_phase = 0;
    int          m_left  = 0;
    logic [15:0] m_prod  = '0;

    always #5 clk = ~clk;

    shift_add_mult dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .product     (product),
        .busy        (busy)
    );

    function automatic int lat_of(input logic [7:0] bv);
`ifdef MULT_EARLY_EXIT_EN
        int m;
        if (bv == 8'd0) return 1;
        m = 0;
        for (int i = 0; i < 8; i++) if (bv[i]) m = i;
        return (m + 2 < 8) ? m + 2 : 8;
`else
        return (bv === 8'hxx) ? 0 : 8;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            m_prod  = '0;
        end else begin
            case (m_phase)
                0: if (start_valid) begin
                       m_phase = 1;
                       m_left  = lat_of(b);
                       m_prod  = 16'(a * b);
                   end
                1: begin
                       m_left--;
                       if (m_left == 0) m_phase = 2;
                   end
                default: if (done_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("start_ready", 32'(start_ready), 32'(m_phase == 0));
        chk("done_valid",  32'(done_valid),  32'(m_phase == 2));
        chk("busy",        32'(busy),        32'(m_phase != 0));
        if (m_phase != 1) chk("product_model", 32'(product), 32'(m_prod));
    end

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv,
                         input logic [15:0] exp_p, input int exp_lat, input int hold);
        int g;
        int cyc;
        a = ta; b = tbv; start_valid = 1'b1; done_ready = 1'b0;
        g = 0;
        while (!start_ready && g < 30) begin @(posedge clk); #1; g++; end
        chk("accept_wait", 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        cyc = 0;
        while (!done_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("product", 32'(product), 32'(exp_p));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_product", 32'(product), 32'(exp_p));
            chk("bp_start_ready", 32'(start_ready), 32'd0);
            chk("bp_done_valid", 32'(done_valid), 32'd1);
        end
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        chk("post_hs_start_ready", 32'(start_ready), 32'd1);
        chk("post_hs_done_valid", 32'(done_valid), 32'd0);
        $display("op a=%0d b=%0d product=%0d latency=%0d", ta, tbv, product, cyc);
    endtask

    task automatic wait_done(input int limit);
        int cyc;
        cyc = 0;
        while (!done_valid && cyc < limit) begin @(posedge clk); #1; cyc++; end
        chk("done_timeout", 32'(done_valid), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_done_valid",  32'(done_valid),  32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_product",     32'(product),     32'd0);
        rst_n = 1'b1;

        do_op(8'd13,  8'd11,  16'd143,   lat_of(8'd11), 0);
`ifndef MULT_EARLY_EXIT_EN
        chk("lat_literal_13x11", 32'(lat_of(8'd11)), 32'd8);
`endif
        do_op(8'd255, 8'd255, 16'hFE01,  lat_of(8'd255), 0);
        do_op(8'd0,   8'd200, 16'd0,     lat_of(8'd200), 0);
        do_op(8'd171, 8'd37,  16'd6327,  lat_of(8'd37), 0);
        do_op(8'd200, 8'd100, 16'd20000, lat_of(8'd100), 5);

        // Reset in the 4th RUN cycle of 7x9
        a = 8'd7; b = 8'd9; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_start_ready", 32'(start_ready), 32'd1);
        chk("midrun_rst_done_valid",  32'(done_valid),  32'd0);
        chk("midrun_rst_busy",        32'(busy),        32'd0);
        chk("midrun_rst_product",     32'(product),     32'd0);
        $display("reset mid-run: product=%0d busy=%0d", product, busy);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(8'd3, 8'd5, 16'd15, lat_of(8'd5), 0);

        // start_valid held high, operands changed during the operation
        a = 8'd2; b = 8'd3; start_valid = 1'b1; done_ready = 1'b1;
        @(posedge clk); #1;
        a = 8'd4; b = 8'd5;
        wait_done(20);
        chk("held_first_product", 32'(product), 32'd6);
        $display("held request 1: product=%0d", product);
        @(posedge clk); #1;
        chk("held_idle_start_ready", 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("held_second_busy", 32'(busy), 32'd1);
        wait_done(20);
        chk("held_second_product", 32'(product), 32'd20);
        $display("held request 2: product=%0d", product);
        @(posedge clk); #1;

        // done_ready held high: done_valid lasts exactly one cycle
        a = 8'd6; b = 8'd7; start_valid = 1'b1; done_ready = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        n = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done_valid) n++;
        end
        chk("dv_pulse_width", 32'(n), 32'd1);
        chk("dv_pulse_product", 32'(product), 32'd42);
        $display("done_ready held: done_valid cycles=%0d product=%0d", n, product);
        done_ready = 1'b0;

`ifdef MULT_EARLY_EXIT_EN
        do_op(8'd77,  8'd0,   16'd0,    1, 0);
        do_op(8'd100, 8'd1,   16'd100,  2, 0);
        do_op(8'd9,   8'h80,  16'd1152, 8, 0);
        do_op(8'd250, 8'd6,   16'd1500, 4, 0);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

- Sequential 8×8 unsigned multiplier controller.
- Computes a 16-bit product by time-sharing one instance of the existing 8-bit ripple-carry adder (RCA) over successive shift-add steps.
- Sits between a requester (operand handshake) and a consumer (result handshake). It is the block that sequences the adder datapath: it drives the adder's A, B and Ci each step and captures S and Co.

## Interface
Parameters:
- None. Operand width is fixed at 8 by the adder; product width is 16.

Ports:
- `clk`  in  1  Single clock; all state updates on its rising edge.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `start_valid`  in  1  Requester presents operands.
- `start_ready`  out  1  Block can accept operands; high only in IDLE.
- `a`  in  8  Multiplicand; sampled on the accept edge.
- `b`  in  8  Multiplier; sampled on the accept edge.
- `done_valid`  out  1  `product` is valid; high only in DONE.
- `done_ready`  in  1  Consumer accepts the product.
- `product`  out  16  Result a×b.
- `busy`  out  1  High in RUN or DONE.

## Operation
- States:
  - IDLE
    - Exit on `start_valid && start_ready` (the accept edge): load `mcand=a`, `acc=0`, `mplr=b`, `cnt=0`, then go to RUN.
  - RUN, one step per cycle:
    - Adder inputs are `A=acc`, `B=mcand`, `Ci=0`.
    - If `mplr[0]=1`: `{acc,mplr} <= {Co,S,mplr}>>1`.
    - Else: `{acc,mplr} <= {1'b0,acc,mplr}>>1`.
    - `cnt` increments each step. After the step with `cnt==7`, go to DONE.
  - DONE
    - `done_valid=1`; `product={acc,mplr}` is held stable.
    - Exit to IDLE on `done_valid && done_ready`.
- `product` is driven from `{acc,mplr}` at all times. It is guaranteed only while `done_valid=1`. In IDLE it retains the last result until the next accept.
- Widths and arithmetic:
  - The adder carry-out forms the 9th bit of the partial sum and is never discarded.
  - No overflow is possible: 255×255=65025 fits in 16 bits.
- `start_valid` or operand changes outside IDLE are ignored. `start_ready=0` outside IDLE.
- `done_ready` outside DONE is ignored.
- Reset values of all outputs: `start_ready=1`, `done_valid=0`, `busy=0`, `product=0`. Internal registers are 0 and the state is IDLE.
- Reset asserted mid-RUN or in DONE: immediate return to IDLE, result discarded, no `done_valid` pulse.

## Timing
- Accept edge E0 → RUN. Steps occur on edges E1..E8. `done_valid` rises after E8, i.e. 8 cycles after the accept edge (base build).
- Minimum DONE residency is 1 cycle.
- DONE→IDLE occurs on the handshake edge. `start_ready` returns the following cycle, so the back-to-back issue interval is 10 cycles.
- `done_ready` may be held high permanently. `done_valid` then remains high for exactly 1 cycle.
- Backpressure: with `done_ready=0`, the block stays in DONE indefinitely and `product` stays constant.

## Configuration
- Macro `MULT_EARLY_EXIT_EN`.
- Undefined: latency is always 8 cycles, as in Timing.
- Defined:
  - At the start of each RUN cycle, if the unconsumed multiplier bits are all zero and `cnt≤7`, that cycle performs a combined right shift of `{acc,mplr}` by `(8−cnt)`, with no adder use, then goes to DONE.
  - Latency = 1 if b==0; otherwise min(m+2, 8), where m is the index of b's highest set bit.
  - Results are identical to the base build.

## Structure
- Package `mult_pkg` holds:
  - state enum `mult_state_t` {IDLE, RUN, DONE};
  - `OP_W=8`, `PROD_W=16`, `CNT_W=4`.
- One sub-module: the existing `RCA`, instantiated once as the shared adder. No other sub-modules. The control FSM and shift registers live in `shift_add_mult`.

## Test plan
- a=13, b=11 → `product=143` (0x008F); `done_valid` exactly 8 cycles after accept (base build).
- a=255, b=255 → `product=65025` (0xFE01); exercises `Co` into `acc`. a=0, b=200 → 0.
- `done_ready=0` for 5 cycles after `done_valid` rises → `product` constant, `start_ready=0` throughout; `done_ready=1` → IDLE next edge, `start_ready=1` one cycle later.
- `rst_n` pulsed low at the 4th RUN cycle of a=7, b=9 → outputs at reset values immediately; next request a=3, b=5 → 15.
- `start_valid=1` with new operands held throughout an operation (a=2, b=3) → result 6, second request accepted only after IDLE reached.
- With `MULT_EARLY_EXIT_EN`:
  - b=0 → latency 1, product 0.
  - a=100, b=1 → latency 2, product 100.
  - a=9, b=0x80 → latency 8, product 1152.
